// File: rtl/button_debounce_pkg.sv
// Shared constants and helpers for the button_debounce glitch filter.
// Optional 2-flop input synchronizer: define BUTTON_DEBOUNCE_SYNC_EN.
package button_debounce_pkg;

  localparam string POL_LOW  = "LOW";
  localparam string POL_HIGH = "HIGH";

  localparam int unsigned TIMEOUT_DEFAULT       = 50000;
  localparam int unsigned TIMEOUT_WIDTH_DEFAULT = 16;

  // Anything other than "LOW" behaves as active-high.
  function automatic logic inactive_level(input string pol);
    return (pol == POL_LOW) ? 1'b1 : 1'b0;
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// One bit of the debouncer: optional synchronizer, saturating counter, output flop.
// Synchronizer present only when BUTTON_DEBOUNCE_SYNC_EN is defined.
module debounce_bit
  import button_debounce_pkg::*;
#(
  parameter string       POLARITY      = POL_LOW,
  parameter int unsigned TIMEOUT       = TIMEOUT_DEFAULT,
  parameter int unsigned TIMEOUT_WIDTH = TIMEOUT_WIDTH_DEFAULT
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic din_i,
  output logic dout_o
);

  localparam logic [TIMEOUT_WIDTH-1:0] LIMIT =
    TIMEOUT_WIDTH'(TIMEOUT - 1);
  localparam logic [TIMEOUT_WIDTH-1:0] SAT =
    TIMEOUT_WIDTH'(TIMEOUT);

  logic inact;
  logic s;

  assign inact = inactive_level(POLARITY);

`ifdef BUTTON_DEBOUNCE_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync_q <= {2{inact}};
    end else begin
      sync_q <= {sync_q[0], din_i};
    end
  end

  assign s = sync_q[1];
`else
  assign s = din_i;
`endif

  logic [TIMEOUT_WIDTH-1:0] cnt_q, cnt_d;
  logic                     out_q, out_d;

  // Counter parks at TIMEOUT so a long hold never wraps back to inactive.
  always_comb begin
    cnt_d = cnt_q;
    out_d = out_q;
    if (s == inact) begin
      cnt_d = '0;
      out_d = inact;
    end else if (cnt_q < LIMIT) begin
      cnt_d = cnt_q + TIMEOUT_WIDTH'(1);
    end else begin
      cnt_d = SAT;
      out_d = ~inact;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
      out_q <= inact;
    end else begin
      cnt_q <= cnt_d;
      out_q <= out_d;
    end
  end

  assign dout_o = out_q;

endmodule

// File: rtl/button_debounce.sv
// Per-bit glitch filter for WIDTH push-button/switch inputs.
// Optional input synchronizer: define BUTTON_DEBOUNCE_SYNC_EN.
module button_debounce
  import button_debounce_pkg::*;
#(
  parameter int unsigned WIDTH         = 4,
  parameter string       POLARITY      = POL_LOW,
  parameter int unsigned TIMEOUT       = TIMEOUT_DEFAULT,
  parameter int unsigned TIMEOUT_WIDTH = TIMEOUT_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .POLARITY      (POLARITY),
      .TIMEOUT       (TIMEOUT),
      .TIMEOUT_WIDTH (TIMEOUT_WIDTH)
    ) u_bit (
      .clk_i   (clk),
      .reset_i (reset),
      .din_i   (data_in[i]),
      .dout_o  (data_out[i])
    );
  end

endmodule

// File: tb/tb_button_debounce.sv
// Scoreboard bench for button_debounce (WIDTH=4, LOW, TIMEOUT=4).
// Model tracks consecutive-active run lengths per bit.
module tb_button_debounce;

  localparam int W  = 4;
  localparam int TO = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] data_in;
  logic [W-1:0] data_out;

  button_debounce #(
    .WIDTH         (W),
    .POLARITY      ("LOW"),
    .TIMEOUT       (TO),
    .TIMEOUT_WIDTH (3)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .data_in  (data_in),
    .data_out (data_out)
  );

  always #5 clk = ~clk;

  logic [W-1:0] exp_q[$];
  int           checks = 0;
  int           passed = 0;

  int           run[W];
  logic [W-1:0] s1 = '1;
  logic [W-1:0] s2 = '1;

  // Model: output active once the run of active samples reaches TO.
  task automatic step(input logic rst, input logic [W-1:0] din);
    logic [W-1:0] smp;
    logic [W-1:0] e;
    @(negedge clk);
    reset   = rst;
    data_in = din;
    e = '1;
    if (rst) begin
      for (int i = 0; i < W; i++) run[i] = 0;
      s1 = '1;
      s2 = '1;
    end else begin
`ifdef BUTTON_DEBOUNCE_SYNC_EN
      smp = s2;
      s2  = s1;
      s1  = din;
`else
      smp = din;
`endif
      for (int i = 0; i < W; i++) begin
        run[i] = (smp[i] == 1'b0) ? run[i] + 1 : 0;
        e[i]   = (run[i] >= TO) ? 1'b0 : 1'b1;
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic hold(input logic [W-1:0] din, input int n);
    for (int k = 0; k < n; k++) step(1'b0, din);
  endtask

  // Monitor: one registered output per edge, popped and compared.
  initial begin
    logic [W-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (data_out === e) passed++;
        else $display("FAIL data_out t=%0t: got %b expected %b",
                      $time, data_out, e);
      end
    end
  end

  initial begin
    logic [W-1:0] d;
    int           budget;
    reset   = 1'b1;
    data_in = '0;
    step(1'b1, 4'b0000);
    step(1'b1, 4'b0000);
    hold(4'b1111, 2);
    hold(4'b1110, 6);
    hold(4'b1111, 2);
    hold(4'b1101, 3);
    hold(4'b1111, 1);
    hold(4'b1101, 3);
    hold(4'b1101, 4);
    hold(4'b1111, 2);
    hold(4'b1011, 20);
    hold(4'b1111, 3);
    hold(4'b0111, 3);
    step(1'b1, 4'b0111);
    hold(4'b0111, 8);
    hold(4'b1111, 2);
    d = 4'b1111;
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < W; i++)
        if ($urandom_range(0, 4) == 0) d[i] = ~d[i];
      step($urandom_range(0, 60) == 0, d);
    end
    hold(4'b0000, 6);
    budget = 0;
    while (exp_q.size() > 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    @(negedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      $display("FAIL drain: %0d pending expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/button_debounce.md
Name: button_debounce

Overview:
- Per-bit glitch filter for WIDTH asynchronous push-button or switch inputs.
- Sits between board pins (e.g. user_pb) and control logic such as the PHY reset and system functions.
- An input bit is reported active only after it has been held at its active level for TIMEOUT consecutive clk cycles.
- Return to the inactive level is reported immediately.
- Output polarity equals input polarity; no inversion.

Parameters:
- WIDTH, 4, number of independent input bits.
- POLARITY, "LOW", active level of inputs and outputs. "LOW" means active = 0 and inactive = 1. Any other value is treated as "HIGH" (active = 1, inactive = 0).
- TIMEOUT, 50000, consecutive active cycles required before the output asserts. Must be ≥ 1. At 50 MHz the default gives 1 ms.
- TIMEOUT_WIDTH, 16, counter width. Must satisfy 2**TIMEOUT_WIDTH > TIMEOUT.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- data_in  input  WIDTH  raw inputs (asynchronous to clk).
- data_out  output  WIDTH  debounced inputs, registered, same polarity as data_in.

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high; the polarity and synchronicity are fixed.
- Reset (reset=1 at a clk edge):
  - every counter is cleared to 0;
  - data_out is set to all-inactive (all 1s for "LOW", all 0s for "HIGH");
  - synchronizer flops, if present, are set to inactive.
- Reset has priority over all other activity and may be asserted mid-count; counting restarts from 0 afterwards.
- Each bit i is fully independent, with its own counter cnt[i] (TIMEOUT_WIDTH bits) and output flop. Per clk edge, when not in reset, with s = sampled data_in[i]:
  - s inactive: cnt[i] <= 0 and data_out[i] <= inactive. Deassertion is immediate: visible one edge after the inactive sample.
  - s active and cnt[i] < TIMEOUT-1: cnt[i] <= cnt[i]+1; data_out[i] holds its value (inactive).
  - s active and cnt[i] ≥ TIMEOUT-1: cnt[i] <= TIMEOUT (saturates, never wraps); data_out[i] <= active.
- Assertion latency: data_out[i] becomes active on the TIMEOUT-th consecutive edge that samples s active.
- A single inactive sample anywhere in the run restarts the count.
- TIMEOUT = 1 means the output follows a registered copy of the input (1-cycle latency).
- Held active indefinitely: output stays active, counter stays at TIMEOUT.
- No handshake and no enable. Simultaneous changes on several bits are processed independently in the same cycle.

Optional Feature:
- Macro: BUTTON_DEBOUNCE_SYNC_EN.
- Defined: each data_in bit passes through a 2-flop synchronizer (reset to inactive) before sampling. s is the second flop output. Assertion latency becomes TIMEOUT+2 edges; deassertion becomes 3 edges.
- Not defined: data_in is sampled directly. The caller guarantees synchronous inputs or accepts metastability risk.

Decomposition:
- Package button_debounce_pkg:
  - polarity string constants "LOW" and "HIGH";
  - default TIMEOUT and TIMEOUT_WIDTH;
  - a function returning the inactive bit value for a given POLARITY.
- Sub-module debounce_bit: one bit's optional synchronizer, counter and output flop.
- button_debounce instantiates WIDTH copies of debounce_bit in a generate loop.

Test Plan:
- Test configuration: WIDTH=4, POLARITY="LOW", TIMEOUT=4, TIMEOUT_WIDTH=3, macro off.
- Reset: data_in=4'b0000 with reset=1 for 2 cycles → data_out=4'b1111. Counters held at 0 while reset is high.
- Clean press: bit0 driven 0 and held → data_out[0] stays 1 for 3 edges and becomes 0 after the 4th edge; other bits stay 1.
- Glitch rejection: bit1 low for 3 cycles, high 1 cycle, low 3 cycles → data_out[1] never leaves 1. Then low for 4 cycles → data_out[1]=0.
- Immediate release plus saturation: bit2 held low for 20 cycles (output 0, no wrap-around toggling), then driven high → data_out[2]=1 one edge later.
- Reset mid-count: bit3 low for 3 cycles, reset pulsed 1 cycle, bit3 kept low → data_out[3] asserts only 4 edges after reset deasserts. Same run with BUTTON_DEBOUNCE_SYNC_EN defined → 6 edges.
